// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller for the ld/sd pipeline stage.
// One access at a time: IDLE accepts, BUSY waits WAIT cycles, DONE pulses ack.
module data_mem_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        stall,
  output logic        ack,
  output logic        misalign
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_wr_q, op_wr_d;
  logic [AW+2:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          mis_q;
  logic [63:0]   rdata_q;
  logic [63:0]   mem [DEPTH];

  logic          req;
  logic          done_edge;
  logic          aligned;
  logic [AW-1:0] idx;

  // Address bits above the doubleword index wrap and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^addr[63:AW+3];

  assign req       = MemRead | MemWrite;
  assign done_edge = (state_q == StBusy) && (cnt_q == 4'd0);
  assign aligned   = (addr_q[2:0] == 3'b000);
  assign idx       = addr_q[AW+2:3];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StBusy;
          cnt_d   = 4'(WAIT - 1);
          op_wr_d = MemWrite;  // a simultaneous read+write is a write only
          addr_d  = addr[AW+2:0];
          wdata_d = wdata;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 64'd0;
      mis_q   <= 1'b0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (done_edge) begin
        mis_q <= ~aligned;
        if (aligned && !op_wr_q) begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

  // Storage is never cleared; a reset on the completing edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && done_edge && aligned && op_wr_q) begin
      mem[idx] <= wdata_q;
    end
  end

  assign rdata    = rdata_q;
  assign ack      = (state_q == StDone);
  assign misalign = (state_q == StDone) & mis_q;
  assign stall    = rst_n & (((state_q == StIdle) & req) | (state_q == StBusy));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DEPTH=32, WAIT=2): vector table of whole
// accesses plus hand-written reset-abort and held-request sequences.
module tb_data_mem_ctrl;

  localparam int unsigned WAIT = 2;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        stall;
  logic        ack;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;

  data_mem_ctrl #(.DEPTH(32), .WAIT(WAIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .ack      (ack),
    .misalign (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a request at the negedge opening cycle T, checks every cycle to T+WAIT+1.
  task automatic do_access(input logic rd, input logic wr, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] exp_rdata,
                           input logic exp_mis, input string name);
    @(negedge clk);
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = wd;
    for (int i = 0; i <= int'(WAIT); i++) begin
      #1;
      check({name, " stall"}, {63'd0, stall}, 64'd1);
      check({name, " ack_early"}, {63'd0, ack}, 64'd0);
      @(negedge clk);
    end
    check({name, " ack"}, {63'd0, ack}, 64'd1);
    check({name, " stall_done"}, {63'd0, stall}, 64'd0);
    check({name, " misalign"}, {63'd0, misalign}, {63'd0, exp_mis});
    check({name, " rdata"}, rdata, exp_rdata);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    check({name, " ack_after"}, {63'd0, ack}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 64'h0,   64'h1111_2222_3333_4444, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 64'h8,   64'h88,                  64'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 64'h10,  64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 64'h10,  64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 64'h18,  64'h1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 64'h18,  64'h0, 64'h1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 64'h14,  64'hBAD, 64'h1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 64'h10,  64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 64'h13,  64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 64'h0,   64'h0, 64'h1111_2222_3333_4444, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 64'h110, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};

    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b1; addr = 64'h10; wdata = 64'h5;
    @(negedge clk);
    @(negedge clk);
    check("reset stall", {63'd0, stall}, 64'd0);
    check("reset ack", {63'd0, ack}, 64'd0);
    check("reset misalign", {63'd0, misalign}, 64'd0);
    check("reset rdata", rdata, 64'd0);
    MemWrite = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle stall", {63'd0, stall}, 64'd0);

    for (int v = 0; v < 11; v++) begin
      do_access(vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].wd, vecs[v].exp_rdata,
                vecs[v].exp_mis, $sformatf("vec%0d", v));
    end

    // Reset during BUSY aborts sd 0x100 (would alias doubleword 0).
    @(negedge clk);
    MemWrite = 1'b1; addr = 64'h100; wdata = 64'h55;
    @(negedge clk);
    rst_n = 1'b0; MemWrite = 1'b0;
    #1;
    check("rstbusy stall_in_reset", {63'd0, stall}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstbusy ack", {63'd0, ack}, 64'd0);
      check("rstbusy rdata", rdata, 64'd0);
    end
    rst_n = 1'b1;
    do_access(1'b1, 1'b0, 64'h0, 64'h0, 64'h1111_2222_3333_4444, 1'b0, "rstbusy ld0");

    // Reset on the edge that would enter DONE suppresses sd 0x8.
    @(negedge clk);
    MemWrite = 1'b1; addr = 64'h8; wdata = 64'h77;
    @(negedge clk);
    MemWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstdone ack", {63'd0, ack}, 64'd0);
    check("rstdone misalign", {63'd0, misalign}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstdone ack_idle", {63'd0, ack}, 64'd0);
    do_access(1'b1, 1'b0, 64'h8, 64'h0, 64'h88, 1'b0, "rstdone ld8");

    // Same store without reset wraps onto doubleword 0.
    do_access(1'b0, 1'b1, 64'h100, 64'h55, 64'h88, 1'b0, "wrap sd");
    do_access(1'b1, 1'b0, 64'h0, 64'h0, 64'h55, 1'b0, "wrap ld0");

    // Request held through DONE: one ack per acceptance, re-accept only from IDLE.
    @(negedge clk);
    MemRead = 1'b1; addr = 64'h18;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("held ack c%0d", c), {63'd0, ack},
            ((c == 3) || (c == 7)) ? 64'd1 : 64'd0);
      check($sformatf("held stall c%0d", c), {63'd0, stall},
            ((c == 3) || (c == 7)) ? 64'd0 : 64'd1);
      @(negedge clk);
    end
    MemRead = 1'b0;
    #1;
    check("held ack_end", {63'd0, ack}, 64'd0);
    check("held stall_end", {63'd0, stall}, 64'd0);
    check("held rdata", rdata, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of 64-bit doublewords stored; power of two, 2..1024.
REQ-002 SHALL have parameter WAIT, default 2, meaning busy cycles per access; range 1..15.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port MemRead  input  1  load request from control path (ld).
REQ-007 SHALL have port MemWrite  input  1  store request from control path (sd).
REQ-008 SHALL have port addr  input  64  byte address from ALU result.
REQ-009 SHALL have port wdata  input  64  store data.
REQ-010 SHALL have port rdata  output  64  last completed load data.
REQ-011 SHALL have port stall  output  1  pipeline hold; combinational.
REQ-012 SHALL have port ack  output  1  one-cycle access-complete pulse; registered state decode.
REQ-013 SHALL have port misalign  output  1  error flag, valid only while ack=1.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL accept a request in cycle T when state=IDLE, rst_n=1 and (MemRead|MemWrite)=1: latch addr, wdata, op; load wait counter with WAIT-1; next state BUSY.
REQ-016 SHALL, when MemRead and MemWrite are both 1 at acceptance, treat the request as a write only; rdata unchanged.
REQ-017 SHALL decrement the counter in BUSY; leave BUSY for DONE on the cycle counter=0.
REQ-018 SHALL drive stall = rst_n & ((state=IDLE & (MemRead|MemWrite)) | state=BUSY); stall is high in cycles T..T+WAIT and low in DONE.
REQ-019 SHALL, in DONE (cycle T+WAIT+1), assert ack=1, perform the memory write at the DONE-entering edge or update rdata, then return to IDLE unconditionally.
REQ-020 SHALL ignore MemRead/MemWrite while in DONE (the requester still presents the completed instruction).
REQ-021 SHALL index memory with addr[2+log2(DEPTH):3]; upper address bits ignored (wrap-around modulo DEPTH doublewords).
REQ-022 SHALL flag misalign when latched addr[2:0]!=0: no memory write, rdata unchanged, misalign=1 with ack.
REQ-023 SHALL hold rdata between completed loads; stores never alter rdata.
REQ-024 SHALL keep ack=0 and misalign=0 in IDLE and BUSY.

Reset
REQ-025 SHALL, on a rising edge with rst_n=0, set state=IDLE, counter=0, rdata=0, ack=0, misalign=0; stall=0 while rst_n=0.
REQ-026 SHALL, if reset occurs in BUSY or at the DONE-entering edge, discard the pending access: no memory write, no ack.
REQ-027 SHALL not clear memory contents on reset.

Verification (WAIT=2, DEPTH=32)
REQ-028 SHALL cover: reset, MemWrite=1 addr=0x10 wdata=0xDEADBEEFCAFEF00D at T -> stall=1 T..T+2, ack=1 T+3, stall=0 T+3, rdata=0.
REQ-029 SHALL cover: then MemRead=1 addr=0x10 -> ack at T+3, rdata=0xDEADBEEFCAFEF00D from T+3 onward, misalign=0.
REQ-030 SHALL cover: MemRead=MemWrite=1 addr=0x18 wdata=0x1 -> write only, rdata unchanged; subsequent ld 0x18 returns 0x1.
REQ-031 SHALL cover: MemWrite=1 addr=0x14 -> ack and misalign=1 at T+3; ld 0x10 still returns 0xDEADBEEFCAFEF00D.
REQ-032 SHALL cover: sd addr=0x100 wdata=0x55, rst_n=0 at T+1 -> no ack, stall=0 during reset, ld 0x0 returns prior value; repeat without reset -> ld 0x0 returns 0x55 (wrap).
REQ-033 SHALL cover: request held high through DONE -> exactly one ack per accepted request, next acceptance only from IDLE.
